// File: rtl/rtp_rx_depack.sv
// rtl/rtp_rx_depack.sv - RTP receive depacketizer with PCM playback FIFO
// Validates RTP header/SSRC, stores big-endian 16-bit samples, drains on wav_rden.
module rtp_rx_depack #(
   parameter logic [15:0] RTP_Header_Param = 16'h8080,
   parameter logic [31:0] SSRC             = 32'h12345678,
   parameter bit          CHECK_SSRC       = 1'b1,
   parameter int          FIFO_DEPTH       = 1024,
   parameter int          START_LEVEL      = 512,
   parameter int          AW               = $clog2(FIFO_DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          udp_rec_data_valid,
   input  logic [7:0]    udp_rec_rdata,
   input  logic [15:0]   udp_rec_data_length,
   input  logic          wav_rden,
   output logic [15:0]   wav_out_data,
   output logic [AW:0]   fifo_level,
   output logic          playing,
   output logic [15:0]   pkt_ok_cnt,
   output logic [15:0]   pkt_drop_cnt,
   output logic [15:0]   seq_gap_cnt,
   output logic [15:0]   underrun_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DROP, S_SKIP} state_t;

   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   seq_cur_q, seq_cur_d;
   logic [7:0]    hi_q, hi_d;
   logic [15:0]   last_seq_q;
   logic          seq_valid_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   fifo_level_q;
   logic [15:0]   wav_out_q;
   logic          playing_q;
   logic [15:0]   ok_cnt_q, drop_cnt_q, gap_cnt_q, under_cnt_q;
   logic [15:0]   mem [FIFO_DEPTH];

   logic          wr_en, accept, drop_evt, hdr_ok, admit_ok, pop, empty;
   logic [15:0]   pay_len;
   logic [AW:0]   free_w;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
      return (en && v != 16'hFFFF) ? v + 16'd1 : v;
   endfunction

   // Admission is decided once, on byte0, against the space free at that moment.
   assign pay_len  = udp_rec_data_length - 16'd12;
   assign free_w   = (AW+1)'(FIFO_DEPTH) - fifo_level_q;
   assign admit_ok = (udp_rec_data_length >= 16'd12) && !pay_len[0]
                     && ({2'b00, pay_len[15:1]} <= 17'(free_w))
                     && (udp_rec_rdata == RTP_Header_Param[15:8]);

   always_comb begin
      hdr_ok = 1'b1;
      case (cnt_q)
         16'd1:   hdr_ok = (udp_rec_rdata[6:0] == RTP_Header_Param[6:0]);
         16'd8:   hdr_ok = !CHECK_SSRC || (udp_rec_rdata == SSRC[31:24]);
         16'd9:   hdr_ok = !CHECK_SSRC || (udp_rec_rdata == SSRC[23:16]);
         16'd10:  hdr_ok = !CHECK_SSRC || (udp_rec_rdata == SSRC[15:8]);
         16'd11:  hdr_ok = !CHECK_SSRC || (udp_rec_rdata == SSRC[7:0]);
         default: hdr_ok = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      seq_cur_d = seq_cur_q;
      hi_d      = hi_q;
      wr_en     = 1'b0;
      accept    = 1'b0;
      drop_evt  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (udp_rec_data_valid) begin
               len_d   = udp_rec_data_length;
               cnt_d   = 16'd1;
               state_d = admit_ok ? S_HDR : S_DROP;
            end
         end
         S_HDR: begin
            if (!udp_rec_data_valid) begin
               drop_evt = 1'b1;
               state_d  = S_IDLE;
            end else if (!hdr_ok) begin
               state_d = S_DROP;
            end else begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == 16'd2) seq_cur_d[15:8] = udp_rec_rdata;
               if (cnt_q == 16'd3) seq_cur_d[7:0]  = udp_rec_rdata;
               if (cnt_q == 16'd11) begin
                  if (len_q == 16'd12) begin
                     accept  = 1'b1;
                     state_d = S_SKIP;
                  end else begin
                     state_d = S_PAYLOAD;
                  end
               end
            end
         end
         S_PAYLOAD: begin
            if (!udp_rec_data_valid) begin
               drop_evt = 1'b1;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
               // Payload starts at an even offset, so even byte indices carry the MSB.
               if (!cnt_q[0]) hi_d  = udp_rec_rdata;
               else           wr_en = 1'b1;
               if (cnt_q == len_q - 16'd1) begin
                  accept  = 1'b1;
                  state_d = S_SKIP;
               end
            end
         end
         S_DROP: begin
            if (!udp_rec_data_valid) begin
               drop_evt = 1'b1;
               state_d  = S_IDLE;
            end
         end
         S_SKIP: begin
            if (!udp_rec_data_valid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign empty = (fifo_level_q == '0);
   assign pop   = wav_rden && playing_q && !empty;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= {hi_q, udp_rec_rdata};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         len_q        <= '0;
         seq_cur_q    <= '0;
         hi_q         <= '0;
         last_seq_q   <= '0;
         seq_valid_q  <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_level_q <= '0;
         wav_out_q    <= '0;
         playing_q    <= 1'b0;
         ok_cnt_q     <= '0;
         drop_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         under_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         seq_cur_q <= seq_cur_d;
         hi_q      <= hi_d;
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
         fifo_level_q <= fifo_level_q + (AW+1)'(wr_en) - (AW+1)'(pop);
         if (wav_rden) wav_out_q <= pop ? mem[rd_ptr_q] : 16'h0000;
         if (wav_rden && playing_q && empty)
            playing_q <= 1'b0;
         else if (!playing_q && fifo_level_q >= (AW+1)'(START_LEVEL))
            playing_q <= 1'b1;
         if (accept) begin
            last_seq_q  <= seq_cur_q;
            seq_valid_q <= 1'b1;
         end
         ok_cnt_q    <= sat_inc(ok_cnt_q, accept);
         drop_cnt_q  <= sat_inc(drop_cnt_q, drop_evt);
         gap_cnt_q   <= sat_inc(gap_cnt_q, accept && seq_valid_q
                                 && (seq_cur_q != last_seq_q + 16'd1));
         under_cnt_q <= sat_inc(under_cnt_q, wav_rden && playing_q && empty);
      end
   end

   assign wav_out_data = wav_out_q;
   assign fifo_level   = fifo_level_q;
   assign playing      = playing_q;
   assign pkt_ok_cnt   = ok_cnt_q;
   assign pkt_drop_cnt = drop_cnt_q;
   assign seq_gap_cnt  = gap_cnt_q;
   assign underrun_cnt = under_cnt_q;

endmodule
